// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round scheduler.
package mole_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

    typedef logic [1:0] level_t;

    localparam int WIN_W = 4;

    // Mole-up window length in ticks, indexed by difficulty level.
    localparam logic [WIN_W-1:0] WIN_TICKS [4] = '{4'd8, 4'd6, 4'd4, 4'd2};

    function automatic logic [WIN_W-1:0] win_ticks(level_t lvl);
        return WIN_TICKS[lvl];
    endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Control/status bundle between the round scheduler and game logic.
interface mole_round_ctrl_if #(
    parameter int RND_W = 5
);
    logic              start;
    mole_pkg::level_t  level;
    logic              hit;
    logic              tick;
    logic              new_mole;
    logic              mole_up;
    logic              busy;
    logic              game_over;
    logic [RND_W-1:0]  round_cnt;
    logic [RND_W-1:0]  hit_cnt;
    logic [RND_W-1:0]  miss_cnt;

    modport master (
        output start, level, hit,
        input  tick, new_mole, mole_up, busy, game_over, round_cnt, hit_cnt, miss_cnt
    );

    modport slave (
        input  start, level, hit,
        output tick, new_mole, mole_up, busy, game_over, round_cnt, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/mole_tick_gen.sv
// Game-tick prescaler: a clock enable on clk rather than a divided clock.
module mole_tick_gen #(
    parameter int TICK_DIV = 4166665,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(TICK_DIV)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == CNT_W'(TICK_DIV));
endmodule

// File: rtl/mole_round_ctrl.sv
// Round scheduler: steps each round through a mole-up window and a gap, keeps score.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int TICK_DIV   = 4166665,
    parameter int CNT_W      = 26,
    parameter int GAP_TICKS  = 2,
    parameter int NUM_ROUNDS = 16,
    parameter int RND_W      = $clog2(NUM_ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    mole_round_ctrl_if.slave  bus
);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    state_t            state_q, state_nx;
    level_t            lvl_q;
    logic [WIN_W-1:0]  win_q;
    logic [GAP_W-1:0]  gap_q;
    logic [RND_W-1:0]  round_q, hit_q, miss_q;
    logic              new_mole_q, mole_up_q, busy_q, game_over_q;
    logic              tick, tick_en, clr;
    logic              start_ev, hit_ev, miss_ev, load_win;

    assign tick_en = (state_q == SHOW) || (state_q == GAP);
    // Restarting the prescaler on every transition makes each dwell a whole number of ticks.
    assign clr     = (state_nx != state_q);

    mole_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        start_ev = 1'b0;
        hit_ev   = 1'b0;
        miss_ev  = 1'b0;
        load_win = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    start_ev = 1'b1;
                    load_win = 1'b1;
                    state_nx = SHOW;
                end
            end
            SHOW: begin
                // A hit on the final tick wins over the timeout.
                if (bus.hit) begin
                    hit_ev   = 1'b1;
                    state_nx = GAP;
                end else if (tick && (win_q == WIN_W'(1))) begin
                    miss_ev  = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (tick && (gap_q == GAP_W'(GAP_TICKS - 1))) begin
                    if (round_q == RND_W'(NUM_ROUNDS)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SHOW;
                        load_win = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q       <= '0;
            win_q       <= '0;
            gap_q       <= '0;
            round_q     <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            new_mole_q  <= 1'b0;
            mole_up_q   <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            if (start_ev) lvl_q <= bus.level;

            if (load_win)                   win_q <= win_ticks(start_ev ? bus.level : lvl_q);
            else if (state_q == SHOW && tick) win_q <= win_q - 1'b1;

            if (state_q != GAP) gap_q <= '0;
            else if (tick)      gap_q <= gap_q + 1'b1;

            if (start_ev) begin
                round_q <= '0;
                hit_q   <= '0;
                miss_q  <= '0;
            end else if (hit_ev) begin
                round_q <= round_q + 1'b1;
                hit_q   <= hit_q + 1'b1;
            end else if (miss_ev) begin
                round_q <= round_q + 1'b1;
                miss_q  <= miss_q + 1'b1;
            end

            new_mole_q  <= (state_nx == SHOW) && (state_q != SHOW);
            mole_up_q   <= (state_nx == SHOW);
            busy_q      <= (state_nx == SHOW) || (state_nx == GAP);
            game_over_q <= (state_nx == DONE);
        end
    end

    assign bus.tick      = tick;
    assign bus.new_mole  = new_mole_q;
    assign bus.mole_up   = mole_up_q;
    assign bus.busy      = busy_q;
    assign bus.game_over = game_over_q;
    assign bus.round_cnt = round_q;
    assign bus.hit_cnt   = hit_q;
    assign bus.miss_cnt  = miss_q;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: cycle-time reference model plus directed game scenarios.
module tb_mole_round_ctrl;
    import mole_pkg::*;

    localparam int TD    = 3;
    localparam int GAP   = 2;
    localparam int NR    = 3;
    localparam int RND_W = $clog2(NR + 1);
    localparam int TP    = TD + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mole_round_ctrl_if #(.RND_W(RND_W)) bus ();

    mole_round_ctrl #(
        .TICK_DIV   (TD),
        .CNT_W      (4),
        .GAP_TICKS  (GAP),
        .NUM_ROUNDS (NR),
        .RND_W      (RND_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: phase and elapsed cycles in phase (0 idle, 1 show, 2 gap, 3 done).
    int m_phase, m_el, m_lvl, m_rnd, m_hit, m_miss;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_el <= 0; m_lvl <= 0;
            m_rnd <= 0; m_hit <= 0; m_miss <= 0;
        end else begin
            case (m_phase)
                0, 3: if (bus.start) begin
                    m_rnd <= 0; m_hit <= 0; m_miss <= 0;
                    m_lvl <= int'(bus.level); m_phase <= 1; m_el <= 0;
                end
                1: if (bus.hit) begin
                    m_hit <= m_hit + 1; m_rnd <= m_rnd + 1; m_phase <= 2; m_el <= 0;
                end else if (m_el == (8 - 2 * m_lvl) * TP - 1) begin
                    m_miss <= m_miss + 1; m_rnd <= m_rnd + 1; m_phase <= 2; m_el <= 0;
                end else begin
                    m_el <= m_el + 1;
                end
                2: if (m_el == GAP * TP - 1) begin
                    m_phase <= (m_rnd == NR) ? 3 : 1; m_el <= 0;
                end else begin
                    m_el <= m_el + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("tick",      int'(bus.tick),      int'((m_phase == 1 || m_phase == 2) && (m_el % TP == TD)));
            chk("new_mole",  int'(bus.new_mole),  int'(m_phase == 1 && m_el == 0));
            chk("mole_up",   int'(bus.mole_up),   int'(m_phase == 1));
            chk("busy",      int'(bus.busy),      int'(m_phase == 1 || m_phase == 2));
            chk("game_over", int'(bus.game_over), int'(m_phase == 3));
            chk("round_cnt", int'(bus.round_cnt), m_rnd);
            chk("hit_cnt",   int'(bus.hit_cnt),   m_hit);
            chk("miss_cnt",  int'(bus.miss_cnt),  m_miss);
        end
    end

    // Timing monitor: new_mole timestamps, game_over rise, last SHOW/GAP run lengths.
    int nm_q[$];
    int go_cyc = -1;
    bit go_prev = 1'b0;
    int up_run = 0, gap_run = 0, last_show = 0, last_gap = 0;

    always @(negedge clk) begin
        if (bus.new_mole) nm_q.push_back(cyc);
        if (bus.game_over && !go_prev) go_cyc <= cyc;
        go_prev <= bus.game_over;
        if (bus.mole_up) up_run <= up_run + 1;
        else begin
            if (up_run != 0) last_show <= up_run;
            up_run <= 0;
        end
        if (bus.busy && !bus.mole_up) gap_run <= gap_run + 1;
        else begin
            if (gap_run != 0) last_gap <= gap_run;
            gap_run <= 0;
        end
    end

    task automatic pulse_start(input int lvl);
        @(negedge clk);
        bus.level = level_t'(lvl);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_hit();
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
    endtask

    task automatic wait_level(input string name, input bit want, input int bound);
        int n = 0;
        while (bus.mole_up != want && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (bus.mole_up != want) chk(name, 0, 1);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int tcnt;
        int n;
        bus.start = 1'b0;
        bus.level = '0;
        bus.hit   = 1'b0;

        // Reset held 5 cycles, then 20 quiet cycles
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_round", int'(bus.round_cnt), 0);
        tcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tick) tcnt++;
        end
        chk("idle_ticks", tcnt, 0);

        // Level 3 game with no hits
        nm_q.delete();
        pulse_start(3);
        n = 0;
        while (!bus.game_over && n < 200) begin @(negedge clk); n++; end
        if (!bus.game_over) chk("go_timeout", 0, 1);
        #1;
        chk("nm_count", nm_q.size(), 3);
        if (nm_q.size() == 3) begin
            chk("nm_gap1", nm_q[1] - nm_q[0], 16);
            chk("nm_gap2", nm_q[2] - nm_q[1], 16);
            chk("go_delay", go_cyc - nm_q[0], 48);
        end
        chk("show_len_l3", last_show, 8);
        chk("gap_len", last_gap, 8);
        chk("g1_miss", int'(bus.miss_cnt), 3);
        chk("g1_hit", int'(bus.hit_cnt), 0);
        chk("g1_round", int'(bus.round_cnt), 3);

        // Hit in DONE is ignored
        @(negedge clk);
        pulse_hit();
        chk("done_hit_ignored", int'(bus.hit_cnt), 0);
        chk("done_round_hold", int'(bus.round_cnt), 3);
        chk("done_hold", int'(bus.game_over), 1);

        // Start from DONE: counters clear; start/level during SHOW ignored
        pulse_start(3);
        chk("restart_round", int'(bus.round_cnt), 0);
        chk("restart_miss", int'(bus.miss_cnt), 0);
        chk("restart_show", int'(bus.mole_up), 1);
        @(negedge clk);
        bus.level = level_t'(0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_level("show_fall_to", 1'b0, 40);
        chk("show_len_ignored", last_show, 8);
        pulse_hit();
        chk("gap_hit_ignored", int'(bus.hit_cnt), 0);
        chk("gap_miss", int'(bus.miss_cnt), 1);

        // Reset mid-GAP of round 2
        wait_level("r2_rise_to", 1'b1, 20);
        wait_level("r2_fall_to", 1'b0, 40);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_round", int'(bus.round_cnt), 2);
        chk("pre_rst_busy", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_round", int'(bus.round_cnt), 0);
        chk("arst_miss", int'(bus.miss_cnt), 0);
        chk("arst_tick", int'(bus.tick), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", int'(bus.busy), 0);

        // Level 0, hit in the 5th cycle of SHOW
        pulse_start(0);
        repeat (4) @(negedge clk);
        pulse_hit();
        chk("l0_hit_cnt", int'(bus.hit_cnt), 1);
        chk("l0_mole_down", int'(bus.mole_up), 0);
        #1;
        chk("l0_show_len", last_show, 5);
        wait_level("l0_gap_to", 1'b1, 20);
        chk("l0_gap_len", last_gap, 8);
        do_reset();

        // Level 3, hit on the final tick counts as hit only
        pulse_start(3);
        repeat (7) @(negedge clk);
        chk("l3_last_tick", int'(bus.tick), 1);
        pulse_hit();
        chk("coinc_hit", int'(bus.hit_cnt), 1);
        chk("coinc_miss", int'(bus.miss_cnt), 0);
        chk("coinc_round", int'(bus.round_cnt), 1);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
